// File: rtl/complementer_pkg.sv
// Shared width, word type and overflow-operand helper for the conditional negator.
// Used by twos_complementer, which has an optional COMPLEMENTER_REG_OUT_EN build.
package complementer_pkg;

    localparam int CMP_WIDTH = 32;

    typedef logic [CMP_WIDTH-1:0] cmp_word_t;

    // The single operand whose negation cannot be represented (most negative value).
    function automatic cmp_word_t min_neg(input int unsigned width);
        return cmp_word_t'(1) << (width - 1);
    endfunction

endpackage

// File: rtl/twos_negate_core.sv
// Purely combinational conditional two's-complement negate with overflow and zero flags.
module twos_negate_core #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic             NEG,
    output logic [WIDTH-1:0] Y,
    output logic             V,
    output logic             Z
);

    logic w_is_min;

    // NOTE: negate as (A ^ {NEG}) + NEG instead of NEG ? ~A+1 : A, so an X on NEG
    // spreads through the adder to Y rather than being merged away where both arms agree.
    assign Y = (A ^ {WIDTH{NEG}}) + {{(WIDTH-1){1'b0}}, NEG};

    assign w_is_min = A[WIDTH-1] && (A[WIDTH-2:0] == '0);
    assign V        = NEG && w_is_min;
    assign Z        = (Y == '0);

endmodule

// File: rtl/twos_complementer.sv
// EX-stage conditional negator with sticky overflow status.
// Define COMPLEMENTER_REG_OUT_EN to register OUT/OVF/ZERO (latency 1); default is combinational.
module twos_complementer
    import complementer_pkg::*;
#(
    parameter int WIDTH = CMP_WIDTH
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [WIDTH-1:0] IN,
    input  logic             COMP_SEL_IDEX,
    input  logic             OVF_CLR,
    output logic [WIDTH-1:0] OUT,
    output logic             OVF,
    output logic             ZERO,
    output logic             OVF_STICKY
);

    logic [WIDTH-1:0] w_y;
    logic             w_ovf;
    logic             w_zero;
    logic             r_ovf_sticky;

    twos_negate_core #(.WIDTH(WIDTH)) u_core (
        .A   (IN),
        .NEG (COMP_SEL_IDEX),
        .Y   (w_y),
        .V   (w_ovf),
        .Z   (w_zero)
    );

    // Sticky flag watches the pre-register overflow so both builds set it on the same edge.
    // NOTE: sequential state uses non-blocking assignments only; blocking here would race
    // against any other clocked block reading r_ovf_sticky on the same edge.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_ovf_sticky <= 1'b0;
        end else if (OVF_CLR) begin
            r_ovf_sticky <= 1'b0;
        end else if (w_ovf) begin
            r_ovf_sticky <= 1'b1;
        end
    end

    assign OVF_STICKY = r_ovf_sticky;

`ifdef COMPLEMENTER_REG_OUT_EN
    logic [WIDTH-1:0] r_out;
    logic             r_ovf;
    logic             r_zero;

    // Reset value describes a zero result: OUT=0 implies ZERO=1.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_out  <= '0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b1;
        end else begin
            r_out  <= w_y;
            r_ovf  <= w_ovf;
            r_zero <= w_zero;
        end
    end

    assign OUT  = r_out;
    assign OVF  = r_ovf;
    assign ZERO = r_zero;
`else
    assign OUT  = w_y;
    assign OVF  = w_ovf;
    assign ZERO = w_zero;
`endif

endmodule

// File: tb/tb_twos_complementer.sv
// Directed, table-driven bench for twos_complementer; follows COMPLEMENTER_REG_OUT_EN if defined.
module tb_twos_complementer;
    import complementer_pkg::*;

    localparam int W = CMP_WIDTH;

    typedef struct {
        logic [W-1:0] vin;
        logic         sel;
        logic [W-1:0] exp_out;
        logic         exp_ovf;
        logic         exp_zero;
    } vec_t;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [W-1:0] IN;
    logic         COMP_SEL_IDEX;
    logic         OVF_CLR;
    logic [W-1:0] OUT;
    logic         OVF;
    logic         ZERO;
    logic         OVF_STICKY;

    int n_checks = 0;
    int n_errors = 0;

    vec_t vecs[10];

    twos_complementer #(.WIDTH(W)) dut (
        .CLK           (CLK),
        .RESET         (RESET),
        .IN            (IN),
        .COMP_SEL_IDEX (COMP_SEL_IDEX),
        .OVF_CLR       (OVF_CLR),
        .OUT           (OUT),
        .OVF           (OVF),
        .ZERO          (ZERO),
        .OVF_STICKY    (OVF_STICKY)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drive on the falling edge, sample 9 ns later (just past the next rising edge),
    // which holds for both the combinational and the registered build.
    task automatic apply(input logic [W-1:0] v, input logic s);
        @(negedge CLK);
        IN            = v;
        COMP_SEL_IDEX = s;
        #9;
    endtask

    initial begin : watchdog
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [W-1:0] mn;
        mn = min_neg(W);

        vecs[0] = '{32'h0000_000A, 1'b0, 32'h0000_000A, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFF_FFFF, 1'b1, 32'h0000_0001, 1'b0, 1'b0};
        vecs[2] = '{32'h0000_0000, 1'b1, 32'h0000_0000, 1'b0, 1'b1};
        vecs[3] = '{32'h0000_0000, 1'b0, 32'h0000_0000, 1'b0, 1'b1};
        vecs[4] = '{32'h8000_0000, 1'b0, 32'h8000_0000, 1'b0, 1'b0};
        vecs[5] = '{32'h8000_0000, 1'b1, 32'h8000_0000, 1'b1, 1'b0};
        vecs[6] = '{32'h0000_0001, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0};
        vecs[7] = '{32'h7FFF_FFFF, 1'b1, 32'h8000_0001, 1'b0, 1'b0};
        vecs[8] = '{32'h0000_0005, 1'b1, 32'hFFFF_FFFB, 1'b0, 1'b0};
        vecs[9] = '{32'h1234_5678, 1'b1, 32'hEDCB_A988, 1'b0, 1'b0};

        RESET         = 1'b0;
        IN            = '0;
        COMP_SEL_IDEX = 1'b0;
        OVF_CLR       = 1'b1;
        #12;
        check("reset_sticky", W'(OVF_STICKY), '0);
`ifdef COMPLEMENTER_REG_OUT_EN
        check("reset_out",  OUT, '0);
        check("reset_zero", W'(ZERO), W'(1));
`endif
        @(negedge CLK);
        RESET = 1'b1;

        // Clear held high throughout the table, so even the overflow row leaves sticky at 0.
        for (int i = 0; i < 10; i++) begin
            apply(vecs[i].vin, vecs[i].sel);
            check($sformatf("vec%0d_out", i),  OUT,      vecs[i].exp_out);
            check($sformatf("vec%0d_ovf", i),  W'(OVF),  W'(vecs[i].exp_ovf));
            check($sformatf("vec%0d_zero", i), W'(ZERO), W'(vecs[i].exp_zero));
        end
        check("table_sticky_clear_wins", W'(OVF_STICKY), '0);

        // Overflow sets sticky on the edge.
        @(negedge CLK);
        OVF_CLR = 1'b0;
        IN = mn; COMP_SEL_IDEX = 1'b1;
        @(posedge CLK); #1;
        check("sticky_set", W'(OVF_STICKY), W'(1));
        check("ovf_at_set", W'(OVF), W'(1));

        // Held with no overflow present.
        @(negedge CLK);
        IN = 32'h0000_000A; COMP_SEL_IDEX = 1'b0;
        @(posedge CLK); @(posedge CLK); #1;
        check("sticky_hold", W'(OVF_STICKY), W'(1));

        // Clear and overflow on the same edge: clear wins.
        @(negedge CLK);
        IN = mn; COMP_SEL_IDEX = 1'b1; OVF_CLR = 1'b1;
        @(posedge CLK); #1;
        check("sticky_clear_vs_ovf", W'(OVF_STICKY), '0);

        // Set again, then clear with a zero operand.
        @(negedge CLK);
        OVF_CLR = 1'b0;
        @(posedge CLK); #1;
        check("sticky_reset_again", W'(OVF_STICKY), W'(1));
        @(negedge CLK);
        IN = '0; COMP_SEL_IDEX = 1'b1; OVF_CLR = 1'b1;
        @(posedge CLK); #1;
        check("sticky_clear_zero", W'(OVF_STICKY), '0);
        check("zero_neg_zero", W'(ZERO), W'(1));

        // Asynchronous reset between edges.
        @(negedge CLK);
        OVF_CLR = 1'b0;
        IN = mn; COMP_SEL_IDEX = 1'b1;
        @(posedge CLK); #1;
        check("sticky_before_rst", W'(OVF_STICKY), W'(1));
        @(negedge CLK);
        #2;
        RESET = 1'b0;
        #1;
        check("sticky_async_rst", W'(OVF_STICKY), '0);
`ifdef COMPLEMENTER_REG_OUT_EN
        check("out_in_rst",  OUT, '0);
        check("ovf_in_rst",  W'(OVF), '0);
        check("zero_in_rst", W'(ZERO), W'(1));
`else
        check("out_in_rst", OUT, mn);
        check("ovf_in_rst", W'(OVF), W'(1));
`endif
        #1;
        RESET = 1'b1;
        @(posedge CLK); #1;
        check("out_after_rst", OUT, mn);

        // Latency: default is immediate, registered build waits exactly one edge.
        @(negedge CLK);
        IN = 32'h0000_0005; COMP_SEL_IDEX = 1'b1;
        #1;
`ifdef COMPLEMENTER_REG_OUT_EN
        check("lat_before_edge", OUT, mn);
`else
        check("lat_before_edge", OUT, 32'hFFFF_FFFB);
`endif
        @(posedge CLK); #1;
        check("lat_after_edge", OUT, 32'hFFFF_FFFB);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
